// File: rtl/lc4_cmp_sched_if.sv
// lc4_cmp_sched_if: requester, comparator and response signals of the shared LC4 comparator scheduler
//   r0_*/r1_*  request channels (valid/ready, op, operands a/b)
//   cmp_a/b    operands to the shared comparator; cmp_16..cmpui_19 its results
//   resp_*     one-entry response buffer (valid/ready, id, data, nzp); done_cnt completed handshakes
interface lc4_cmp_sched_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              r0_valid, r0_ready, r1_valid, r1_ready;
    logic [1:0]        r0_op, r1_op;
    logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [DATA_W-1:0] cmp_a, cmp_b, cmp_16, cmpu_17, cmpi_18, cmpui_19;
    logic              resp_valid, resp_ready, resp_id;
    logic [DATA_W-1:0] resp_data;
    logic [2:0]        resp_nzp;
    logic [CNT_W-1:0]  done_cnt;
    modport master (
        output r0_valid, r0_op, r0_a, r0_b, r1_valid, r1_op, r1_a, r1_b,
        output cmp_16, cmpu_17, cmpi_18, cmpui_19, resp_ready,
        input  r0_ready, r1_ready, cmp_a, cmp_b, resp_valid, resp_id, resp_data, resp_nzp, done_cnt
    );
    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b, r1_valid, r1_op, r1_a, r1_b,
        input  cmp_16, cmpu_17, cmpi_18, cmpui_19, resp_ready,
        output r0_ready, r1_ready, cmp_a, cmp_b, resp_valid, resp_id, resp_data, resp_nzp, done_cnt
    );
endinterface

// File: rtl/lc4_cmp_sched.sv
// lc4_cmp_sched: round-robin sharing of one LC4 comparator between two requesters with a one-entry response buffer
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         lc4_cmp_sched_if slave: request channels, comparator operands/results, response buffer
module lc4_cmp_sched #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    lc4_cmp_sched_if.slave    bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t            r_state;
    logic              r_last, r_id;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_nzp;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_can, w_any, w_gnt, w_acc;
    logic [1:0]        w_op;
    logic [DATA_W-1:0] w_res;
    assign w_can = (r_state == EMPTY) | bus.resp_ready;
    assign w_any = bus.r0_valid | bus.r1_valid;
    // on contention alternate away from the last accepted requester
    assign w_gnt = (bus.r0_valid & bus.r1_valid) ? ~r_last : bus.r1_valid;
    assign bus.r0_ready = w_can & bus.r0_valid & ~w_gnt;
    assign bus.r1_ready = w_can & bus.r1_valid & w_gnt;
    assign w_acc = bus.r0_ready | bus.r1_ready;
    assign w_op = w_gnt ? bus.r1_op : bus.r0_op;
    assign bus.cmp_a = w_any ? (w_gnt ? bus.r1_a : bus.r0_a) : '0;
    assign bus.cmp_b = w_any ? (w_gnt ? bus.r1_b : bus.r0_b) : '0;
    assign w_res = w_op == 2'd0 ? bus.cmp_16 : w_op == 2'd1 ? bus.cmpu_17 : w_op == 2'd2 ? bus.cmpi_18 : bus.cmpui_19;
    assign bus.resp_valid = (r_state == FULL);
    assign bus.resp_id = r_id;
    assign bus.resp_data = r_data;
    assign bus.resp_nzp = r_nzp;
    assign bus.done_cnt = r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_data  <= '0;
            r_nzp   <= 3'b000;
            r_cnt   <= '0;
        end else begin
            if (r_state == FULL && bus.resp_ready)
                r_cnt <= r_cnt + 1'b1;
            if (w_acc) begin
                r_state <= FULL;
                r_last  <= w_gnt;
                r_id    <= w_gnt;
                r_data  <= w_res;
                r_nzp   <= {w_res[DATA_W-1], w_res == '0, ~w_res[DATA_W-1] & (w_res != '0)};
            end else if (bus.resp_ready) begin
                r_state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_lc4_cmp_sched.sv
// tb_lc4_cmp_sched: directed checks of lc4_cmp_sched against a golden LC4 comparator model
module tb_lc4_cmp_sched;
    localparam int DW = 16;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    lc4_cmp_sched_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    lc4_cmp_sched #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic logic [15:0] cmpv(input logic signed [16:0] x, input logic signed [16:0] y);
        return x < y ? 16'hFFFF : (x == y ? 16'h0000 : 16'h0001);
    endfunction
    assign bus.cmp_16   = cmpv({bus.cmp_a[15], bus.cmp_a}, {bus.cmp_b[15], bus.cmp_b});
    assign bus.cmpu_17  = cmpv({1'b0, bus.cmp_a}, {1'b0, bus.cmp_b});
    assign bus.cmpi_18  = cmpv({bus.cmp_a[15], bus.cmp_a}, {{10{bus.cmp_b[6]}}, bus.cmp_b[6:0]});
    assign bus.cmpui_19 = cmpv({1'b0, bus.cmp_a}, {10'b0, bus.cmp_b[6:0]});
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic resp(input string tag, input logic v, input logic id, input logic [15:0] d, input logic [2:0] nzp);
        chk({tag, ".valid"}, 32'(bus.resp_valid), 32'(v));
        chk({tag, ".id"}, 32'(bus.resp_id), 32'(id));
        chk({tag, ".data"}, 32'(bus.resp_data), 32'(d));
        chk({tag, ".nzp"}, 32'(bus.resp_nzp), 32'(nzp));
    endtask
    initial begin
        bus.r0_valid = 0; bus.r0_op = 0; bus.r0_a = 0; bus.r0_b = 0;
        bus.r1_valid = 0; bus.r1_op = 0; bus.r1_a = 0; bus.r1_b = 0;
        bus.resp_ready = 1;
        repeat (2) @(negedge clk);
        resp("reset", 0, 0, 16'h0000, 3'b000);
        chk("reset.done", 32'(bus.done_cnt), 0);
        chk("idle.r0_ready", 32'(bus.r0_ready), 0);
        chk("idle.cmp_a", 32'(bus.cmp_a), 0);
        rst_n = 1;
        // 1: r0 CMP -1 vs 1
        @(negedge clk);
        bus.r0_valid = 1; bus.r0_op = 2'd0; bus.r0_a = 16'hFFFF; bus.r0_b = 16'h0001;
        #1;
        chk("t1.r0_ready", 32'(bus.r0_ready), 1);
        chk("t1.r1_ready", 32'(bus.r1_ready), 0);
        chk("t1.cmp_a", 32'(bus.cmp_a), 32'hFFFF);
        @(posedge clk); #1;
        resp("t1", 1, 0, 16'hFFFF, 3'b100);
        // 2: r1 CMPU then CMPUI
        @(negedge clk);
        bus.r0_valid = 0;
        bus.r1_valid = 1; bus.r1_op = 2'd1; bus.r1_a = 16'hFFFF; bus.r1_b = 16'h0001;
        #1;
        chk("t2.r1_ready", 32'(bus.r1_ready), 1);
        @(posedge clk); #1;
        resp("t2a", 1, 1, 16'h0001, 3'b001);
        chk("t2a.done", 32'(bus.done_cnt), 1);
        @(negedge clk);
        bus.r1_op = 2'd3; bus.r1_a = 16'h0040; bus.r1_b = 16'hFFC0;
        @(posedge clk); #1;
        resp("t2b", 1, 1, 16'h0000, 3'b010);
        chk("t2b.done", 32'(bus.done_cnt), 2);
        @(negedge clk);
        bus.r1_valid = 0;
        @(posedge clk); #1;
        chk("t2.drain.valid", 32'(bus.resp_valid), 0);
        chk("t2.drain.done", 32'(bus.done_cnt), 3);
        // 3: both valid every cycle, grants alternate starting with r0
        @(negedge clk);
        bus.r0_valid = 1; bus.r0_op = 2'd0; bus.r0_a = 16'h0005; bus.r0_b = 16'h0003;
        bus.r1_valid = 1; bus.r1_op = 2'd0; bus.r1_a = 16'h0003; bus.r1_b = 16'h0005;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t3.%0d.r0_ready", i), 32'(bus.r0_ready), 32'(i % 2 == 0));
            chk($sformatf("t3.%0d.r1_ready", i), 32'(bus.r1_ready), 32'(i % 2 == 1));
            @(posedge clk); #1;
            chk($sformatf("t3.%0d.id", i), 32'(bus.resp_id), 32'(i % 2));
            chk($sformatf("t3.%0d.data", i), 32'(bus.resp_data), (i % 2 == 1) ? 32'hFFFF : 32'h0001);
            @(negedge clk);
        end
        chk("t3.done", 32'(bus.done_cnt), 8);
        // 4: consumer stalls for 3 cycles, then drain and fill on the same edge
        bus.resp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4.%0d.r0_ready", i), 32'(bus.r0_ready), 0);
            chk($sformatf("t4.%0d.r1_ready", i), 32'(bus.r1_ready), 0);
            @(posedge clk); #1;
            resp($sformatf("t4.%0d", i), 1, 1, 16'hFFFF, 3'b100);
            chk($sformatf("t4.%0d.done", i), 32'(bus.done_cnt), 8);
            @(negedge clk);
        end
        bus.resp_ready = 1;
        #1;
        chk("t4.rel.r0_ready", 32'(bus.r0_ready), 1);
        @(posedge clk); #1;
        resp("t4.rel", 1, 0, 16'h0001, 3'b001);
        chk("t4.rel.done", 32'(bus.done_cnt), 9);
        // 5: async reset while FULL
        @(negedge clk);
        rst_n = 0;
        #1;
        resp("t5.rst", 0, 0, 16'h0000, 3'b000);
        chk("t5.rst.done", 32'(bus.done_cnt), 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("t5.r0_ready", 32'(bus.r0_ready), 1);
        chk("t5.r1_ready", 32'(bus.r1_ready), 0);
        @(posedge clk); #1;
        resp("t5", 1, 0, 16'h0001, 3'b001);
        chk("t5.done", 32'(bus.done_cnt), 0);
        // 6: 16 handshakes wrap the 4-bit counter
        repeat (15) @(posedge clk);
        #1;
        chk("t6.done15", 32'(bus.done_cnt), 15);
        @(posedge clk); #1;
        chk("t6.wrap", 32'(bus.done_cnt), 0);
        @(negedge clk);
        bus.r0_valid = 0; bus.r1_valid = 0;
        @(posedge clk); #1;
        chk("t6.drain.valid", 32'(bus.resp_valid), 0);
        chk("t6.drain.done", 32'(bus.done_cnt), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
